// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block: FSM states,
// divider iteration count and the stuck-level duty helper.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DIVIDE
  } state_t;

  localparam int unsigned DIV_ITER = 8;

  function automatic logic [7:0] stuck_duty(input logic level);
    return level ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/pwm_duty_div.sv
// Serial restoring divider producing an 8-bit quotient in DIV_ITER cycles.
// The caller guarantees num < den*256, so the quotient always fits.
module pwm_duty_div
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W+7:0] num,
  input  logic [CNT_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [7:0]       quot
);

  logic [CNT_W+7:0] rem;
  logic [CNT_W+7:0] dsh;
  logic [CNT_W+7:0] rem_sub;
  logic [7:0]       q;
  logic [2:0]       step;
  logic             fit;

  // The last quotient bit is resolved combinationally so done can coincide
  // with the final iteration rather than one cycle after it.
  always_comb begin
    fit     = (rem >= dsh);
    rem_sub = rem - dsh;
    quot    = {q[6:0], fit};
    done    = busy && (step == 3'(DIV_ITER - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      rem  <= '0;
      dsh  <= '0;
      q    <= '0;
      step <= '0;
    end else if (start) begin
      busy <= 1'b1;
      rem  <= num;
      dsh  <= {1'b0, den, 7'b0};
      q    <= '0;
      step <= '0;
    end else if (busy) begin
      if (fit) rem <= rem_sub;
      q    <= quot;
      dsh  <= dsh >> 1;
      step <= step + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an external PWM pin and reports an
// 8-bit duty value scaled 0..255, with timeout and overrun reporting.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned     CNT_W       = 16,
  parameter int unsigned     SYNC_STAGES = 2,
  parameter logic [CNT_W-1:0] TIMEOUT    = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [7:0]       duty,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             stuck,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   pwm_s, prev_s, rise;
  state_t                 state;
  logic [CNT_W-1:0]       per_cnt, hi_cnt, p_lat, h_lat;
  logic                   skip, timed_out;
  logic                   per_sat, timeout_hit, div_start;
  logic [CNT_W+7:0]       div_num;
  logic                   div_busy, div_done;
  logic [7:0]             div_quot;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= '0;
      prev_s <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], pwm_in};
      prev_s <= pwm_s;
    end
  end

  always_comb begin
    pwm_s       = sync[SYNC_STAGES-1];
    rise        = pwm_s & ~prev_s;
    per_sat     = (per_cnt == CNT_MAX);
    timeout_hit = en && !rise && !timed_out && (state != DIVIDE) && (per_cnt >= TIMEOUT);
    div_start   = en && rise && (state == ARMED) && !per_sat && !skip;
    div_num     = {hi_cnt, 8'b0} - {8'b0, hi_cnt};
  end

  pwm_duty_div #(.CNT_W(CNT_W)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .num   (div_num),
    .den   (per_cnt),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot)
  );

  // skip marks a period that began during DIVIDE; its closing rise is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      per_cnt   <= '0;
      hi_cnt    <= '0;
      p_lat     <= '0;
      h_lat     <= '0;
      skip      <= 1'b0;
      timed_out <= 1'b0;
      duty      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      stuck     <= 1'b0;
      overrun   <= 1'b0;
    end else if (!en) begin
      state <= IDLE;
      skip  <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (rise) begin
        per_cnt   <= CNT_W'(1);
        hi_cnt    <= CNT_W'(1);
        timed_out <= 1'b0;
      end else begin
        if (!per_sat) per_cnt <= per_cnt + 1'b1;
        if (pwm_s && (hi_cnt != CNT_MAX)) hi_cnt <= hi_cnt + 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (rise) begin
            state <= ARMED;
            skip  <= 1'b0;
          end
        end
        ARMED: begin
          if (rise) begin
            if (div_start) begin
              p_lat <= per_cnt;
              h_lat <= hi_cnt;
              state <= DIVIDE;
            end
            skip <= 1'b0;
          end
        end
        DIVIDE: begin
          if (rise) begin
            overrun <= 1'b1;
            skip    <= 1'b1;
          end
          if (div_done) begin
            duty      <= div_quot;
            period    <= p_lat;
            high_time <= h_lat;
            stuck     <= 1'b0;
            valid     <= 1'b1;
          end else if (!div_busy) begin
            state <= ARMED;
          end
        end
        default: state <= IDLE;
      endcase

      if (timeout_hit) begin
        duty      <= stuck_duty(pwm_s);
        period    <= '0;
        high_time <= '0;
        stuck     <= 1'b1;
        valid     <= 1'b1;
        timed_out <= 1'b1;
        state     <= IDLE;
      end
    end
  end

endmodule
